// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH+1 cycles accept-to-idle (done after WIDTH).
// start is only sampled in IDLE; requests while busy are dropped, never queued.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] sreg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             neg;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] sreg_nxt;
    logic             last_iter;

    // The kept partial remainder is always below the divisor, so its top bit
    // is zero and only WIDTH bits are stored; the trial subtract is WIDTH+1 wide.
    always_comb begin
        shifted   = {prem, sreg[WIDTH-1]};
        diff      = shifted - {1'b0, dvsr};
        neg       = diff[WIDTH];
        prem_nxt  = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        sreg_nxt  = {sreg[WIDTH-2:0], ~neg};
        last_iter = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // sreg doubles as the dividend shifter and the quotient accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvsr        <= '0;
            prem        <= '0;
            sreg        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        dvsr <= divisor;
                        prem <= '0;
                        sreg <= dividend;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt  <= cnt + 1'b1;
                    prem <= prem_nxt;
                    sreg <= sreg_nxt;
                    if (last_iter) begin
                        quotient    <= sreg_nxt;
                        remainder   <= prem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
